time_set_ctrl: RTL and testbench

//  Front-panel controller for the digital clock. Debounces the MODE and INC keys.

---
 rtl/time_set_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Front-panel controller: key debounce, RUN/SET_HOUR/SET_MIN mode FSM, adjust strobes and digit blink.
// Optional build macro AUTO_REPEAT_EN adds INC hold-to-repeat.
module time_set_ctrl #(
  parameter int DB_CYCLES      = 1_000_000,
  parameter int BLINK_HALF     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int HOLD_CYCLES    = 25_000_000,
  parameter int REP_CYCLES     = 5_000_000
) (
  input  logic       CLK_50M,
  input  logic       nCR,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic       run_en,
  output logic       adj_hour,
  output logic       adj_min,
  output logic [1:0] mode,
  output logic [3:0] digit_on
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_HALF - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  if (DB_CYCLES < 1 || BLINK_HALF < 1 || TIMEOUT_CYCLES < 1 ||
      HOLD_CYCLES < 1 || REP_CYCLES < 1) begin : g_bad_params
    $error("time_set_ctrl: all cycle parameters must be at least 1");
  end

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_SET_HOUR = 2'b01,
    S_SET_MIN  = 2'b10
  } state_t;

  // Bit 0 is the MODE key, bit 1 is the INC key.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            level_q, level_d;
  logic [1:0]            evt_q, evt_d;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

  state_t                state_q, state_d;
  logic                  adj_hour_q, adj_hour_d;
  logic                  adj_min_q, adj_min_d;
  logic [TO_W-1:0]       idle_q, idle_d;
  logic [BL_W-1:0]       blink_q, blink_d;
  logic                  phase_q, phase_d;

  logic                  mode_evt, inc_evt, inc_level;
  logic                  in_set, rep_stb, inc_fire, enter_set;

  // Debounce: count consecutive samples that disagree with the accepted level.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      level_d[i]  = level_q[i];
      evt_d[i]    = 1'b0;
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          level_d[i] = sync2_q[i];
          evt_d[i]   = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK_50M or negedge nCR) begin
    if (!nCR) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      evt_q    <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= {key_inc, key_mode};
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      evt_q    <= evt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign mode_evt  = evt_q[0];
  assign inc_evt   = evt_q[1];
  assign inc_level = level_q[1];
  assign in_set    = (state_q != S_RUN);

`ifdef AUTO_REPEAT_EN
  localparam int RP_TOP = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
  localparam int RP_W   = (RP_TOP > 1) ? $clog2(RP_TOP) : 1;
  localparam logic [RP_W-1:0] HOLD_MAX = RP_W'(HOLD_CYCLES - 1);
  localparam logic [RP_W-1:0] REP_MAX  = RP_W'(REP_CYCLES - 1);

  logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
  logic            rp_on_q, rp_on_d;

  // First the hold period, then a strobe every REP_CYCLES while INC stays down.
  always_comb begin
    rp_cnt_d = '0;
    rp_on_d  = 1'b0;
    rep_stb  = 1'b0;
    if (inc_level && in_set && !mode_evt) begin
      rp_on_d = rp_on_q;
      if (rp_on_q) begin
        if (rp_cnt_q == REP_MAX) begin
          rep_stb = 1'b1;
        end else begin
          rp_cnt_d = rp_cnt_q + RP_W'(1);
        end
      end else if (rp_cnt_q == HOLD_MAX) begin
        rep_stb = 1'b1;
        rp_on_d = 1'b1;
      end else begin
        rp_cnt_d = rp_cnt_q + RP_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_50M or negedge nCR) begin
    if (!nCR) begin
      rp_cnt_q <= '0;
      rp_on_q  <= 1'b0;
    end else begin
      rp_cnt_q <= rp_cnt_d;
      rp_on_q  <= rp_on_d;
    end
  end
`else
  assign rep_stb = 1'b0;
`endif

  assign inc_fire = inc_evt | rep_stb;

  // MODE beats INC; any key activity beats the timeout.
  always_comb begin
    state_d    = state_q;
    adj_hour_d = 1'b0;
    adj_min_d  = 1'b0;
    if (mode_evt) begin
      case (state_q)
        S_RUN:      state_d = S_SET_HOUR;
        S_SET_HOUR: state_d = S_SET_MIN;
        default:    state_d = S_RUN;
      endcase
    end else if (inc_fire) begin
      if (state_q == S_SET_HOUR) begin
        adj_hour_d = 1'b1;
      end else if (state_q == S_SET_MIN) begin
        adj_min_d = 1'b1;
      end
    end else if (in_set && idle_q == TO_MAX) begin
      state_d = S_RUN;
    end
  end

  always_comb begin
    idle_d = idle_q;
    if (!in_set || mode_evt || inc_fire) begin
      idle_d = '0;
    end else if (idle_q != TO_MAX) begin
      idle_d = idle_q + TO_W'(1);
    end
  end

  assign enter_set = (state_d != S_RUN) && (state_d != state_q);

  // Restart the blink visible whenever editing starts or a digit is bumped.
  always_comb begin
    blink_d = '0;
    phase_d = 1'b1;
    if (state_d != S_RUN && !enter_set && !adj_hour_d && !adj_min_d) begin
      if (blink_q == BL_MAX) begin
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BL_W'(1);
        phase_d = phase_q;
      end
    end
  end

  always_ff @(posedge CLK_50M or negedge nCR) begin
    if (!nCR) begin
      state_q    <= S_RUN;
      adj_hour_q <= 1'b0;
      adj_min_q  <= 1'b0;
      idle_q     <= '0;
      blink_q    <= '0;
      phase_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      adj_hour_q <= adj_hour_d;
      adj_min_q  <= adj_min_d;
      idle_q     <= idle_d;
      blink_q    <= blink_d;
      phase_q    <= phase_d;
    end
  end

  always_comb begin
    case (state_q)
      S_SET_HOUR: digit_on = {phase_q, phase_q, 2'b11};
      S_SET_MIN:  digit_on = {2'b11, phase_q, phase_q};
      default:    digit_on = 4'b1111;
    endcase
  end

  assign mode     = state_q;
  assign run_en   = (state_q == S_RUN);
  assign adj_hour = adj_hour_q;
  assign adj_min  = adj_min_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with small timing parameters.
module tb_time_set_ctrl;

  localparam int DB = 4;
  localparam int BH = 8;
  localparam int TO = 64;
  localparam int HC = 16;
  localparam int RC = 4;

  logic       clk = 1'b0;
  logic       nCR = 1'b1;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic       run_en, adj_hour, adj_min;
  logic [1:0] mode;
  logic [3:0] digit_on;

  int checks = 0;
  int errors = 0;
  int hour_cnt = 0;
  int min_cnt = 0;
  int both_hi = 0;
  int mode_chg = 0;
  logic [1:0] mode_prev = 2'b00;
  int k;
  int n;
  int pos [8];

  always #5 clk = ~clk;

  time_set_ctrl #(
    .DB_CYCLES(DB), .BLINK_HALF(BH), .TIMEOUT_CYCLES(TO),
    .HOLD_CYCLES(HC), .REP_CYCLES(RC)
  ) dut (
    .CLK_50M(clk), .nCR(nCR), .key_mode(key_mode), .key_inc(key_inc),
    .run_en(run_en), .adj_hour(adj_hour), .adj_min(adj_min),
    .mode(mode), .digit_on(digit_on)
  );

  always @(posedge clk) begin
    #1;
    if (adj_hour === 1'b1) hour_cnt++;
    if (adj_min === 1'b1) min_cnt++;
    if (adj_hour === 1'b1 && adj_min === 1'b1) both_hi++;
    if (mode !== mode_prev) mode_chg++;
    mode_prev = mode;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic press_mode();
    key_mode = 1'b1;
    step(8);
    key_mode = 1'b0;
    step(8);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) pos[i] = -1;

    // 1: reset values, then idle in RUN
    #1 nCR = 1'b0;
    #1;
    chk("rst_mode", mode, 2'b00);
    chk("rst_run_en", run_en, 1'b1);
    chk("rst_digit_on", digit_on, 4'b1111);
    chk("rst_adj", {adj_hour, adj_min}, 2'b00);
    @(negedge clk);
    nCR = 1'b1;
    hour_cnt = 0; min_cnt = 0; mode_chg = 0;
    step(20);
    chk("idle_mode", mode, 2'b00);
    chk("idle_run_en", run_en, 1'b1);
    chk("idle_digit_on", digit_on, 4'b1111);
    chk("idle_adj_hour_cnt", hour_cnt, 0);
    chk("idle_adj_min_cnt", min_cnt, 0);

    // 2: bouncing MODE key, single accepted press, hour digits blink
    key_mode = 1'b1; step(1);
    key_mode = 1'b0; step(1);
    key_mode = 1'b1; step(1);
    key_mode = 1'b0; step(1);
    key_mode = 1'b1;
    k = 0;
    while (mode !== 2'b01 && k < 20) begin step(1); k++; end
    chk("bounce_latency", k, 7);
    key_mode = 1'b0;
    chk("sethour_run_en", run_en, 1'b0);
    chk("blink_k0", digit_on, 4'b1111);
    step(7);
    chk("blink_k7", digit_on, 4'b1111);
    step(1);
    chk("blink_k8", digit_on, 4'b0011);
    step(7);
    chk("blink_k15", digit_on, 4'b0011);
    step(1);
    chk("blink_k16", digit_on, 4'b1111);
    chk("bounce_one_event", mode_chg, 1);

    // 3: three INC presses in SET_MIN
    press_mode();
    chk("setmin_mode", mode, 2'b10);
    hour_cnt = 0; min_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      key_inc = 1'b1;
      k = 0;
      while (adj_min !== 1'b1 && k < 12) begin step(1); k++; end
      chk("inc_latency", k, 7);
      step(1);
      chk("adj_min_one_cycle", adj_min, 1'b0);
      chk("min_digits_visible", digit_on[1:0], 2'b11);
      key_inc = 1'b0;
      step(8);
    end
    chk("setmin_adj_min_cnt", min_cnt, 3);
    chk("setmin_adj_hour_cnt", hour_cnt, 0);

    // 4: MODE and INC accepted on the same cycle in SET_HOUR
    press_mode();
    press_mode();
    chk("sim_pre_mode", mode, 2'b01);
    hour_cnt = 0; min_cnt = 0;
    key_mode = 1'b1; key_inc = 1'b1;
    step(8);
    key_mode = 1'b0; key_inc = 1'b0;
    step(8);
    chk("sim_mode", mode, 2'b10);
    chk("sim_no_hour", hour_cnt, 0);
    chk("sim_no_min", min_cnt, 0);

    // 5: timeout back to RUN, then asynchronous reset in SET_MIN
    press_mode();
    key_mode = 1'b1;
    k = 0;
    while (mode !== 2'b01 && k < 20) begin step(1); k++; end
    key_mode = 1'b0;
    chk("to_entry_latency", k, 7);
    step(63);
    chk("to_still_set", mode, 2'b01);
    step(1);
    chk("to_mode", mode, 2'b00);
    chk("to_run_en", run_en, 1'b1);
    chk("to_digit_on", digit_on, 4'b1111);
    press_mode();
    press_mode();
    chk("arst_pre_mode", mode, 2'b10);
    #2 nCR = 1'b0;
    #1;
    chk("arst_mode", mode, 2'b00);
    chk("arst_run_en", run_en, 1'b1);
    chk("arst_digit_on", digit_on, 4'b1111);
    chk("arst_adj", {adj_hour, adj_min}, 2'b00);
    @(negedge clk);
    nCR = 1'b1;
    step(2);

    // 6: INC held for 40 cycles in SET_HOUR
    press_mode();
    chk("hold_pre_mode", mode, 2'b01);
    key_inc = 1'b1;
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      if (adj_hour === 1'b1) begin
        if (n < 8) pos[n] = c;
        n++;
      end
    end
    key_inc = 1'b0;
    step(12);
    hour_cnt = 0;
    step(10);
    chk("hold_stops_after_release", hour_cnt, 0);
    chk("hold_mode", mode, 2'b01);
`ifdef AUTO_REPEAT_EN
    chk("hold_strobe_cnt", n, 6);
    chk("hold_first", pos[0], 7);
    chk("hold_rep1", pos[1], 22);
    chk("hold_rep2", pos[2], 26);
    chk("hold_rep5", pos[5], 38);
`else
    chk("hold_strobe_cnt", n, 1);
    chk("hold_first", pos[0], 7);
`endif
    chk("never_both_adj", both_hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
